// File: rtl/cmos_serial_add_ctrl.sv
// cmos_serial_add_ctrl
// Bit-serial adder sequencer. It time-shares one external half adder to add two
// WIDTH-bit operands. Each bit takes two half-adder phases:
//   P1: operand bits A[i], B[i]         -> s1 (partial sum), c1 (partial carry)
//   P2: partial sum s1 with carry c     -> result bit i, next carry c1 | cout
//
// Optional feature macro: SERIAL_ADD_CIN_EN adds a carry-in port `cin`. When the
// macro is defined, the carry register starts at cin and the result is a+b+cin.
//
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   rst      in   synchronous active-high reset
//   start    in   start request, sampled only in IDLE
//   a, b     in   WIDTH-bit operands, captured when start is accepted
//   busy     out  high in P1/P2 (2*WIDTH cycles)
//   done     out  one-cycle pulse once sum/cout are valid
//   sum      out  registered WIDTH-bit result
//   cout     out  registered carry-out of the MSB
//   ha_a     out  half-adder input A
//   ha_b     out  half-adder input B
//   ha_sum   in   half-adder sum return
//   ha_cout  in   half-adder carry return
//   cin      in   carry-in (only with SERIAL_ADD_CIN_EN)
module cmos_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ha_a,
  output logic             ha_b,
  input  logic             ha_sum,
  input  logic             ha_cout
`ifdef SERIAL_ADD_CIN_EN
  ,
  input  logic             cin
`endif
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic [IW-1:0]    i_reg;
  logic             s1_reg;
  logic             c1_reg;
  logic             c_reg;

  logic             carry_init;
  logic             last_bit;
  logic             carry_next;

`ifdef SERIAL_ADD_CIN_EN
  assign carry_init = cin;
`else
  assign carry_init = 1'b0;
`endif

  assign last_bit = (i_reg == IW'(WIDTH - 1));

  // The two terms can never both be 1 for a real half adder, but the OR is kept
  // so the sequencer does not rely on that property.
  assign carry_next = c1_reg | ha_cout;

  // Result register with the P2 sum bit merged in at position i; used both for
  // the running result and for the final load of sum.
  always_comb begin
    res_next        = res_reg;
    res_next[i_reg] = ha_sum;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = P1;
      P1:      state_next = P2;
      P2:      state_next = last_bit ? DONE : P1;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: purely from state and registers, so there is no
  // combinational loop through the external half adder.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    ha_a = 1'b0;
    ha_b = 1'b0;
    case (state_reg)
      P1: begin
        busy = 1'b1;
        ha_a = a_reg[i_reg];
        ha_b = b_reg[i_reg];
      end
      P2: begin
        busy = 1'b1;
        ha_a = s1_reg;
        ha_b = c_reg;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      i_reg    <= '0;
      s1_reg   <= 1'b0;
      c1_reg   <= 1'b0;
      c_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // sum/cout keep the previous result until the new one is ready.
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            i_reg <= '0;
            c_reg <= carry_init;
          end
        end
        P1: begin
          s1_reg <= ha_sum;
          c1_reg <= ha_cout;
        end
        P2: begin
          res_reg <= res_next;
          c_reg   <= carry_next;
          if (last_bit) begin
            sum_reg  <= res_next;
            cout_reg <= carry_next;
          end else begin
            i_reg <= i_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_cmos_serial_add_ctrl.sv
`timescale 1ns/1ps
module tb_cmos_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst, start, cin;
  logic [7:0] a, b, sum;
  logic       busy, done, cout, ha_a, ha_b, ha_sum, ha_cout;

  // Behavioural stand-in for the switch-level half adder
  assign ha_sum  = ha_a ^ ha_b;
  assign ha_cout = ha_a & ha_b;

  cmos_serial_add_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .ha_a    (ha_a),
    .ha_b    (ha_b),
    .ha_sum  (ha_sum),
    .ha_cout (ha_cout)
`ifdef SERIAL_ADD_CIN_EN
    ,
    .cin     (cin)
`endif
  );

  // WIDTH=4 instance for the exhaustive sweep
  logic       start4;
  logic [3:0] a4, b4, sum4;
  logic       busy4, done4, cout4, ha_a4, ha_b4, ha_sum4, ha_cout4;

  assign ha_sum4  = ha_a4 ^ ha_b4;
  assign ha_cout4 = ha_a4 & ha_b4;

  cmos_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .start   (start4),
    .a       (a4),
    .b       (b4),
    .busy    (busy4),
    .done    (done4),
    .sum     (sum4),
    .cout    (cout4),
    .ha_a    (ha_a4),
    .ha_b    (ha_b4),
    .ha_sum  (ha_sum4),
    .ha_cout (ha_cout4)
`ifdef SERIAL_ADD_CIN_EN
    ,
    .cin     (1'b0)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] sb_q[$];
  logic [4:0] sb4_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       probe;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One WIDTH=8 addition with a one-cycle start pulse.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic [7:0] es, input logic ec, input logic probe);
    int busy_cnt;
    int guard;
    logic [8:0] exp;
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    sb_q.push_back({ec, es});
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    guard = 0;
    while (done !== 1'b1 && guard < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (probe && guard == 0) begin
        check("p1_ha_a", ha_a, 1'b1);
        check("p1_ha_b", ha_b, 1'b1);
      end
      if (probe && guard == 1) begin
        check("p2_ha_a", ha_a, 1'b0);
        check("p2_ha_b", ha_b, 1'b0);
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("done_timeout", done, 1'b1);
    check("busy_cycles", busy_cnt, 16);
    check("done_cycle", guard, 16);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1FF;
    check("sum", sum, exp[7:0]);
    check("cout", cout, exp[8]);
    $display("op8 a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d busy_cycles=%0d",
             av, bv, cv, sum, cout, busy_cnt);
    @(negedge clk);
    check("done_width", done, 1'b0);
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] bv);
    int busy_cnt;
    int guard;
    logic [4:0] exp;
    logic [4:0] got;
    @(negedge clk);
    a4 = av; b4 = bv; start4 = 1'b1;
    sb4_q.push_back({1'b0, av} + {1'b0, bv});
    @(negedge clk);
    start4 = 1'b0;
    busy_cnt = 0;
    guard = 0;
    while (done4 !== 1'b1 && guard < 50) begin
      if (busy4 === 1'b1) busy_cnt++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("done4_timeout", done4, 1'b1);
    check("busy4_cycles", busy_cnt, 8);
    exp = (sb4_q.size() > 0) ? sb4_q.pop_front() : 5'h1F;
    got = {cout4, sum4};
    check("sweep_result", got, exp);
    $display("op4 a=%01h b=%01h -> cout_sum=%02h", av, bv, got);
    @(negedge clk);
    check("done4_width", done4, 1'b0);
  endtask

  initial begin
    int pulses;
    int last_k;
    logic [8:0] exp;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0, 1'b0};
`ifdef SERIAL_ADD_CIN_EN
    vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
`else
    vecs[7] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
`endif

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_ha_a", ha_a, 1'b0);
    check("rst_ha_b", ha_b, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++)
      run8(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sum, vecs[v].cout, vecs[v].probe);

    // start held high: one result every 18 cycles; operand changes mid-op ignored
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    repeat (3) sb_q.push_back(9'h002);
    pulses = 0;
    last_k = -1;
    for (int k = 0; k < 53; k++) begin
      @(negedge clk);
      if (k == 5 || k == 23) begin a = 8'h7F; b = 8'h7F; end
      if (k == 10 || k == 28) begin a = 8'h01; b = 8'h01; end
      if (done === 1'b1) begin
        pulses++;
        if (last_k >= 0) check("held_period", k - last_k, 18);
        else check("held_first", k, 16);
        last_k = k;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1FF;
        check("held_sum", sum, exp[7:0]);
        check("held_cout", cout, exp[8]);
        $display("held op a=01 b=01 -> sum=%02h cout=%0d at cycle %0d", sum, cout, k);
      end
    end
    start = 1'b0;
    check("held_pulses", pulses, 3);

    // reset in the middle of 0x80+0x80
    @(negedge clk);
    a = 8'h80; b = 8'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, 8'h00);
    check("abort_cout", cout, 1'b0);
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", pulses, 0);
    $display("abort op a=80 b=80 -> sum=%02h cout=%0d", sum, cout);
    run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0);

    // exhaustive WIDTH=4 sweep
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        run4(4'(ia), 4'(ib));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmos_serial_add_ctrl.md
# cmos_serial_add_ctrl

Bit-serial adder sequencer that time-shares one switch-level `cmos_halfAdder` instance to add two WIDTH-bit operands. Each operand bit takes two half-adder phases: operand bits first, then partial sum with the running carry. The half adder sits outside this block and connects through the `ha_*` ports. The block presents a start/busy/done handshake to the surrounding logic.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request an addition; sampled only in IDLE.
- `a` input WIDTH: operand A; captured when start is accepted.
- `b` input WIDTH: operand B; captured when start is accepted.
- `busy` output 1: high while an addition is in progress (states P1, P2).
- `done` output 1: one-cycle pulse when the result is valid.
- `sum` output WIDTH: registered result.
- `cout` output 1: registered carry-out of the MSB.
- `ha_a` output 1: drives half-adder input A.
- `ha_b` output 1: drives half-adder input B.
- `ha_sum` input 1: half-adder sum return.
- `ha_cout` input 1: half-adder carry return.
- `cin` input 1: carry-in; present only with `SERIAL_ADD_CIN_EN`.

## Operation
- States: IDLE, P1, P2, DONE.
- **IDLE**
  - `ha_a` = `ha_b` = 0.
  - On `start` = 1: capture `a`, `b` into shift registers; clear bit index `i` to 0; initialise carry register `c` to 0 (or `cin` with the macro); go to P1.
  - `sum` and `cout` are not cleared on start; they hold the previous result until overwritten.
- **P1 (bit i)**
  - `ha_a` = A[i], `ha_b` = B[i].
  - At the edge: `s1` <= `ha_sum`, `c1` <= `ha_cout`; go to P2.
- **P2 (bit i)**
  - `ha_a` = `s1`, `ha_b` = `c`.
  - At the edge: result bit i <= `ha_sum`; `c` <= `c1` | `ha_cout`.
  - If `i` = WIDTH-1: load `sum` from the result shift register, load `cout` <= `c1` | `ha_cout`, go to DONE.
  - Otherwise: `i` <= `i`+1, go to P1.
- **DONE**
  - `done` = 1 for exactly this cycle; go to IDLE unconditionally.
  - `start` is ignored in DONE.
- `start` is ignored in P1, P2 and DONE: no queuing, no restart, and the captured operands are unaffected.
- `c1` | `ha_cout` never has both terms set (half-adder property); the OR is still implemented as written.
- `ha_a`/`ha_b` are decoded combinationally from state and registers only; there is no path from `ha_sum`/`ha_cout` to `ha_a`/`ha_b`.
- Reset values:
  - state IDLE; `busy`, `done`, `cout` = 0; `sum` = 0; `ha_a`, `ha_b` = 0.
  - internal `i`, `s1`, `c1`, `c` = 0.
- Reset during P1/P2/DONE aborts the operation. No `done` pulse follows, and `sum`/`cout` return to 0.

## Timing
- Edge 0 is the edge that samples `start` = 1 in IDLE.
- `busy` is high from edge 0 through edge 2·WIDTH, i.e. for 2·WIDTH cycles.
- `sum`/`cout` update at edge 2·WIDTH.
- `done` is high for the cycle after edge 2·WIDTH; the next `start` can be accepted at edge 2·WIDTH+2.
- Throughput: one addition per 2·WIDTH+2 cycles (18 cycles for WIDTH=8).
- The half-adder path (`ha_a`/`ha_b` out, `ha_sum`/`ha_cout` back) is combinational and must settle within one clock period.

## Configuration
- `SERIAL_ADD_CIN_EN` defined:
  - The `cin` port exists and is sampled with `a`/`b` on start acceptance.
  - The carry register initialises to `cin`, so the result is `a`+`b`+`cin`.
- `SERIAL_ADD_CIN_EN` undefined:
  - No `cin` port; the carry initialises to 0.
  - The result is `a`+`b`.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x3C, one-cycle `start` → `busy` high 16 cycles, `done` pulse at cycle 17, `sum`=0x96, `cout`=0.
- `a`=0xFF, `b`=0x01 → `sum`=0x00, `cout`=1; during bit 0, P1 shows `ha_a`=`ha_b`=1 and P2 shows `ha_a`=0, `ha_b`=0.
- `start` held high continuously with `a`=0x01, `b`=0x01 → exactly one `done` per 18 cycles, `sum`=0x02 each time. Changing `a`/`b` mid-operation does not alter the result.
- Assert `rst` at cycle 5 of an operation on 0x80+0x80 → no `done`; `sum`=0, `cout`=0, `busy`=0 the cycle after reset; a new `start` then completes normally with `sum`=0x00, `cout`=1.
- With `SERIAL_ADD_CIN_EN`: `a`=0xFF, `b`=0x00, `cin`=1 → `sum`=0x00, `cout`=1. Without the macro, the same operands give `sum`=0xFF, `cout`=0.
- Exhaustive WIDTH=4 sweep with the real `cmos_halfAdder` connected: all 256 operand pairs → `{cout,sum}` equals `a`+`b`; every `done` pulse lasts exactly 1 cycle.
